// File: rtl/gate_pkg.sv
// Shared constants and types for the gate arbiter: default sizes, opcode
// encoding and FSM state encoding.
package gate_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 8;

  typedef enum logic [1:0] {
    OP_NOT = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_XOR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/gate_arbiter_if.sv
// Requester/result bus of the gate arbiter; requesters drive through the
// master modport, the arbiter sits on the slave modport.
interface gate_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 8
);
  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] op;
  logic [W*N_REQ-1:0] a;
  logic [W*N_REQ-1:0] b;
  logic [N_REQ-1:0]   gnt;
  logic               busy;
  logic [W-1:0]       result;
  logic               res_valid;
  logic [1:0]         res_id;

  modport master (
    output req, op, a, b,
    input  gnt, busy, result, res_valid, res_id
  );

  modport slave (
    input  req, op, a, b,
    output gnt, busy, result, res_valid, res_id
  );
endinterface

// File: rtl/gate_unit.sv
// Combinational bitwise gate: NOT a, a AND b, a OR b, a XOR b.
module gate_unit
  import gate_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  op_t          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_NOT: y = ~a;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
    endcase
  end

endmodule

// File: rtl/gate_arbiter.sv
// Round-robin arbiter that captures one requester's opcode and operands,
// runs them through gate_unit and reports the result with the owner's index.
module gate_arbiter
  import gate_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  gate_arbiter_if.slave bus
);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_ptr;
  logic [1:0]       r_win;
  op_t              r_op;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_result;
  logic [1:0]       r_res_id;
  logic [N_REQ-1:0] r_gnt;

  logic             w_found;
  logic [1:0]       w_sel;
  logic [W-1:0]     w_y;

  // First active requester scanning upward from the pointer, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_ptr;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!w_found && bus.req[2'((32'(r_ptr) + i) % N_REQ)]) begin
        w_found = 1'b1;
        w_sel   = 2'((32'(r_ptr) + i) % N_REQ);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_found) w_next = S_EXEC;
      S_EXEC:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  gate_unit #(.W(W)) u_gate (
    .op (r_op),
    .a  (r_a),
    .b  (r_b),
    .y  (w_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_win    <= '0;
      r_op     <= OP_NOT;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_res_id <= '0;
      r_gnt    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_found) begin
          r_win <= w_sel;
          r_op  <= op_t'(bus.op[2*w_sel +: 2]);
          r_a   <= bus.a[W*w_sel +: W];
          r_b   <= bus.b[W*w_sel +: W];
          r_gnt <= N_REQ'(1) << w_sel;
        end
        S_EXEC: begin
          r_result <= w_y;
          r_res_id <= r_win;
        end
        S_DONE: begin
          r_gnt <= '0;
          r_ptr <= 2'((32'(r_win) + 1) % N_REQ);
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.res_valid = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.res_id    = r_res_id;

endmodule

// File: tb/tb_gate_arbiter.sv
// Directed scoreboard bench for gate_arbiter: the driver queues expected
// (res_id, result, cycle) entries, the monitor checks each res_valid pulse.
module tb_gate_arbiter;

  typedef struct {
    logic [1:0]  id;
    logic [7:0]  res;
    int unsigned due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_pass;
  exp_t        sb[$];
  exp_t        got;

  gate_arbiter_if #(.N_REQ(4), .W(8)) bus ();

  gate_arbiter #(.N_REQ(4), .W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Sampling edge is the next posedge; res_valid is seen at the negedge after the following posedge.
  task automatic push(input logic [1:0] id, input logic [7:0] res, input int unsigned samp_off);
    exp_t e;
    e.id  = id;
    e.res = res;
    e.due = cyc + samp_off + 1;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while (bus.busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) check("idle_timeout", 1, 0);
  endtask

  task automatic set_req(input int unsigned i, input logic [1:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    bus.op[2*i +: 2] = op;
    bus.a[8*i +: 8]  = a;
    bus.b[8*i +: 8]  = b;
  endtask

  always @(negedge clk) begin
    if (bus.res_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_res_valid: got res_id=%0d result=%0h, required no pulse (cycle %0d)",
                 bus.res_id, bus.result, cyc);
      end else begin
        got = sb.pop_front();
        check("res_id", 32'(bus.res_id), 32'(got.id));
        check("result", 32'(bus.result), 32'(got.res));
        check("latency", cyc, got.due);
      end
    end
  end

  logic [7:0] opc_exp [4];

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.op   = '0;
    bus.a    = '0;
    bus.b    = '0;
    opc_exp  = '{8'h33, 8'h88, 8'hEE, 8'h66};

    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_res_valid", 32'(bus.res_valid), 0);
    check("rst_result", 32'(bus.result), 0);
    check("rst_res_id", 32'(bus.res_id), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request on requester 0: NOT 0F.
    set_req(0, 2'b00, 8'h0F, 8'h55);
    bus.req = 4'b0001;
    push(2'd0, 8'hF0, 1);
    @(negedge clk);
    check("single_gnt_exec", 32'(bus.gnt), 32'h1);
    check("single_busy", 32'(bus.busy), 1);
    bus.req = '0;
    @(negedge clk);
    check("single_gnt_done", 32'(bus.gnt), 32'h1);
    @(negedge clk);
    check("single_gnt_clear", 32'(bus.gnt), 0);
    check("single_busy_clear", 32'(bus.busy), 0);

    // All opcodes on requester 2.
    for (int unsigned k = 0; k < 4; k++) begin
      wait_idle();
      set_req(2, 2'(k), 8'hCC, 8'hAA);
      bus.req = 4'b0100;
      push(2'd2, opc_exp[k], 1);
      @(negedge clk);
      check("opc_gnt", 32'(bus.gnt), 32'h4);
      bus.req = '0;
      @(negedge clk);
      @(negedge clk);
    end

    // Pointer now 3: requesters 0 and 2 held give 0, 2, 0.
    wait_idle();
    set_req(0, 2'b01, 8'h11, 8'h0F);
    set_req(2, 2'b11, 8'hCC, 8'hAA);
    bus.req = 4'b0101;
    push(2'd0, 8'h01, 1);
    push(2'd2, 8'h66, 4);
    push(2'd0, 8'h01, 7);
    repeat (7) @(posedge clk);
    @(negedge clk);
    bus.req = '0;

    // Operands/requests changed while busy must not affect the captured op.
    wait_idle();
    set_req(0, 2'b11, 8'h3C, 8'h0F);
    bus.req = 4'b0001;
    push(2'd0, 8'h33, 1);
    @(negedge clk);
    set_req(0, 2'b00, 8'hFF, 8'h00);
    bus.req = 4'b1110;
    @(negedge clk);
    check("stable_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;

    // Reset in EXEC: outputs clear at once, no result for the abandoned op.
    wait_idle();
    set_req(1, 2'b01, 8'hFF, 8'h0F);
    bus.req = 4'b0010;
    @(negedge clk);
    check("rst_mid_gnt_before", 32'(bus.gnt), 32'h2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_gnt", 32'(bus.gnt), 0);
    check("rst_mid_busy", 32'(bus.busy), 0);
    check("rst_mid_res_valid", 32'(bus.res_valid), 0);
    check("rst_mid_result", 32'(bus.result), 0);
    check("rst_mid_res_id", 32'(bus.res_id), 0);
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // No requests: stays idle.
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      check("noreq_busy", 32'(bus.busy), 0);
      check("noreq_gnt", 32'(bus.gnt), 0);
    end

    // All four held continuously from pointer 0: 0,1,2,3,0 every 3 cycles.
    for (int unsigned i = 0; i < 4; i++) set_req(i, 2'b00, 8'(1 << i), 8'h00);
    bus.req = 4'b1111;
    push(2'd0, 8'hFE, 1);
    push(2'd1, 8'hFD, 4);
    push(2'd2, 8'hFB, 7);
    push(2'd3, 8'hF7, 10);
    push(2'd0, 8'hFE, 13);
    @(negedge clk);
    check("rr_first_gnt", 32'(bus.gnt), 32'h1);
    repeat (12) @(posedge clk);
    @(negedge clk);
    bus.req = '0;

    begin
      int unsigned n;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
